// File: rtl/div_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// div_sequencer_pkg
// Shared definitions for the MIPS DIV/DIVU sequencer:
//   - default operand width and iteration count
//   - FSM state encoding (2-bit)
// No ports; imported by div_sequencer and div_sequencer_step.
// -----------------------------------------------------------------------------
package div_sequencer_pkg;

  localparam int DIV_WIDTH_DEF  = 32;
  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_sequencer_step.sv
// -----------------------------------------------------------------------------
// div_sequencer_step
// One combinational radix-2 restoring division iteration.
// Working register layout: {partial remainder [2W:W], dividend/quotient [W-1:0]}.
// Ports:
//   work_i     2W+1  working register before the step
//   divisor_i  W     divisor magnitude
//   work_o     2W+1  working register after the step (new quotient bit in bit 0)
// -----------------------------------------------------------------------------
module div_sequencer_step
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [2*WIDTH:0] work_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [2*WIDTH:0] work_o
);

  logic [2*WIDTH:0] shifted_s;
  logic [WIDTH+1:0] trial_s;

  // Shift, trial-subtract from the upper half, keep the difference if non-negative.
  always_comb begin
    shifted_s = work_i << 1;
    // One extra bit above the W+1-bit upper half carries the borrow/sign.
    trial_s   = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, divisor_i};
    if (trial_s[WIDTH+1] == 1'b0) begin
      work_o = {trial_s[WIDTH:0], shifted_s[WIDTH-1:1], 1'b1};
    end else begin
      work_o = shifted_s;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Multi-cycle DIV/DIVU controller in the EX stage. Latches operands on start,
// runs DIV_CYCLES restoring iterations, then presents quotient (lo) and
// remainder (hi) with result_valid until the pipeline advances.
// Ports:
//   clk           core clock
//   resetn        asynchronous reset, active-low
//   start         DIV/DIVU in EX (held while the instruction stays in EX)
//   signed_div    1 = DIV, 0 = DIVU (sampled with start)
//   op_a          dividend (sampled with start)
//   op_b          divisor  (sampled with start)
//   annul         synchronous flush; aborts any operation
//   hold          external stall; keeps a finished result in place
//   stall         request to freeze IF..EX (combinational)
//   result_valid  hi/lo hold a fresh result for the instruction in EX
//   hi            remainder
//   lo            quotient
// -----------------------------------------------------------------------------
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             annul,
  input  logic             hold,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  // Two's complement negate when neg is set.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] value,
                                                input logic             neg);
    logic [WIDTH-1:0] res;
    if (neg) begin
      res = ~value + WIDTH'(1);
    end else begin
      res = value;
    end
    return res;
  endfunction

  div_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [2*WIDTH:0] work_q;
  logic [WIDTH-1:0] divisor_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             valid_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [2*WIDTH:0] work_next_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  // Operand magnitudes for signed division; unsigned passes operands through.
  always_comb begin
    a_neg_s = signed_div & op_a[WIDTH-1];
    b_neg_s = signed_div & op_b[WIDTH-1];
    a_mag_s = cond_neg(op_a, a_neg_s);
    b_mag_s = cond_neg(op_b, b_neg_s);
  end

  div_sequencer_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_next_s)
  );

  // Sign fix-up of the result produced by the final iteration.
  always_comb begin
    quot_fix_s = cond_neg(work_next_s[WIDTH-1:0], neg_quot_q);
    rem_fix_s  = cond_neg(work_next_s[2*WIDTH-1:WIDTH], neg_rem_q);
  end

  // DONE means the instruction may advance, so it never stalls there.
  assign stall        = start & ~annul & (state_q != DIV_DONE);
  assign result_valid = valid_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

  // Sequencer FSM, iteration counter, working register and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= DIV_IDLE;
      count_q    <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      valid_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (annul) begin
      // Flush: drop the operation, leave hi/lo untouched.
      state_q <= DIV_IDLE;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (op_b == '0) begin
              // Divide by zero completes immediately without iterating.
              state_q <= DIV_DONE;
              valid_q <= 1'b1;
              lo_q    <= '1;
              hi_q    <= op_a;
            end else begin
              state_q    <= DIV_ON;
              count_q    <= '0;
              work_q     <= {{(WIDTH+1){1'b0}}, a_mag_s};
              divisor_q  <= b_mag_s;
              neg_quot_q <= a_neg_s ^ b_neg_s;
              neg_rem_q  <= a_neg_s;
            end
          end else begin
            state_q <= DIV_IDLE;
          end
        end
        DIV_ON: begin
          work_q  <= work_next_s;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_q <= DIV_DONE;
            count_q <= '0;
            valid_q <= 1'b1;
            lo_q    <= quot_fix_s;
            hi_q    <= rem_fix_s;
          end else begin
            state_q <= DIV_ON;
          end
        end
        DIV_DONE: begin
          // A start seen here is the same instruction; never restart from DONE.
          if (hold) begin
            state_q <= DIV_DONE;
          end else begin
            state_q <= DIV_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          count_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
// Self-checking bench: a behavioural model (remaining-cycle counter plus
// 64-bit arithmetic for the quotient/remainder) is compared with the DUT on
// every falling edge, directed cases pin literal results and latencies, and
// a randomized phase mixes holds, annuls and special operands.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        stall;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  div_sequencer #(
    .WIDTH      (32),
    .DIV_CYCLES (32)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .op_a         (op_a),
    .op_b         (op_b),
    .annul        (annul),
    .hold         (hold),
    .stall        (stall),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference quotient/remainder via 64-bit arithmetic: {rem, quot}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural model: m_left = iteration cycles still to go, m_done = result presented.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
    end else if (annul) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (!hold) m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_hi   <= p_hi;
        m_lo   <= p_lo;
      end
    end else if (start) begin
      if (op_b == 32'd0) begin
        m_done <= 1'b1;
        m_hi   <= op_a;
        m_lo   <= 32'hFFFF_FFFF;
      end else begin
        m_left <= 32;
        {p_hi, p_lo} <= ref_div(op_a, op_b, signed_div);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_stall", {31'd0, stall}, {31'd0, start & ~annul & ~m_done});
    chk("cyc_valid", {31'd0, result_valid}, {31'd0, m_done});
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
  end

  // Issue one DIV/DIVU; called shortly after a rising edge with the block idle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int ann_at, input int hold_n, input bit lit,
                        input logic [31:0] e_lo, input logic [31:0] e_hi, input bit scramble);
    int k;
    int nst;
    int exp_lat;
    logic [31:0] prev_lo, prev_hi;
    exp_lat = (b == 32'd0) ? 1 : 33;
    prev_lo = m_lo;
    prev_hi = m_hi;
    start = 1'b1; signed_div = s; op_a = a; op_b = b;
    k = 0; nst = 0;
    while (k < 100) begin
      if (k == ann_at) annul = 1'b1;
      #1;
      if (annul) begin
        chk({tag, "_annul_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_annul_valid"}, {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        #1;
        chk({tag, "_post_annul_valid"}, {31'd0, result_valid}, 32'd0);
        chk({tag, "_post_annul_lo"}, lo, prev_lo);
        chk({tag, "_post_annul_hi"}, hi, prev_hi);
        return;
      end
      nst += int'(stall);
      if (result_valid) break;
      @(posedge clk); #1;
      k++;
      if (scramble) begin
        op_a = $urandom;
        op_b = $urandom;
      end
    end
    chk({tag, "_latency"}, k, exp_lat);
    chk({tag, "_stall_cycles"}, nst, exp_lat);
    if (lit) begin
      chk({tag, "_lo"}, lo, e_lo);
      chk({tag, "_hi"}, hi, e_hi);
    end
    for (int i = 0; i < hold_n; i++) begin
      hold = 1'b1;
      @(posedge clk); #2;
      chk({tag, "_hold_valid"}, {31'd0, result_valid}, 32'd1);
      if (lit) begin
        chk({tag, "_hold_lo"}, lo, e_lo);
        chk({tag, "_hold_hi"}, hi, e_hi);
      end
    end
    hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk({tag, "_idle_after"}, {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          sel, ann, gap;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_hi", hi, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("udiv_7_2", 32'd7, 32'd2, 1'b0, -1, 0, 1'b1, 32'd3, 32'd1, 1'b0);
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, -1, 0, 1'b1,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("div_zero", 32'h0000_1234, 32'd0, 1'b0, -1, 0, 1'b1,
           32'hFFFF_FFFF, 32'h0000_1234, 1'b0);
    run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 0, 1'b1,
           32'h8000_0000, 32'd0, 1'b0);
    run_op("annul", 32'd100, 32'd7, 1'b0, 10, 0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    run_op("after_annul", 32'd100, 32'd7, 1'b0, -1, 0, 1'b1, 32'd14, 32'd2, 1'b0);
    run_op("hold5", 32'd1000, 32'd10, 1'b0, -1, 5, 1'b1, 32'd100, 32'd0, 1'b0);
    run_op("sdiv_zero_neg", 32'hFFFF_FF00, 32'd0, 1'b1, -1, 1, 1'b1,
           32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b0);
    run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, -1, 0, 1'b1,
           32'hFFFF_FFFD, 32'd1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      rs  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
        2: rb = 32'd1;
        default: ;
      endcase
      ann = -1;
      if (rb != 32'd0 && $urandom_range(0, 5) == 0) ann = int'($urandom_range(1, 32));
      run_op("rnd", ra, rb, rs, ann, int'($urandom_range(0, 3)), 1'b0, 32'd0, 32'd0, 1'b1);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
